// File: rtl/bram_request_responder_if.sv
// rtl/bram_request_responder_if.sv - request/response FIFO port bundle between requester and responder
// The requester (master) owns the FIFO outputs; the responder (slave) drives the pop/push side.
interface bram_request_responder_if;
  logic [40:0] req_data;
  logic        req_empty;
  logic        req_read;
  logic [40:0] resp_data;
  logic        resp_full;
  logic        resp_write;

  modport master (
    output req_data, req_empty, resp_full,
    input  req_read, resp_data, resp_write
  );

  modport slave (
    input  req_data, req_empty, resp_full,
    output req_read, resp_data, resp_write
  );
endinterface

// File: rtl/bram_request_responder.sv
// rtl/bram_request_responder.sv - block-RAM responder for the 41-bit request/response FIFO protocol
// Optional ADDR_CHECK_EN: reject requests whose address lies beyond the implemented RAM.
module bram_request_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  bram_request_responder_if.slave bus,
  output logic [3:0]              state_out,
  output logic [15:0]             txn_count,
  output logic [15:0]             err_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

  state_t               state;
  state_t               state_next;
  logic [40:0]          req_q;
  logic [15:0]          rdata;
  logic [15:0]          mem [0:(1 << ADDR_BITS) - 1];
  logic                 op;
  logic [23:0]          addr;
  logic [15:0]          wdata;
  logic [ADDR_BITS-1:0] idx;
  logic                 addr_ok;
  logic [15:0]          resp_payload;
  logic                 push;

  assign op        = req_q[40];
  assign addr      = req_q[39:16];
  assign wdata     = req_q[15:0];
  assign idx       = addr[ADDR_BITS-1:0];
  assign state_out = {2'b00, state};
  assign push      = (state == RESP) && !bus.resp_full;

`ifdef ADDR_CHECK_EN
  assign addr_ok = (addr >> ADDR_BITS) == 24'd0;
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    resp_payload = op ? wdata : rdata;
    if (!addr_ok) resp_payload = 16'hDEAD;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!bus.req_empty) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (!bus.resp_full) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_q          <= '0;
      bus.req_read   <= 1'b0;
      bus.resp_write <= 1'b0;
      bus.resp_data  <= '0;
      txn_count      <= '0;
    end else begin
      state          <= state_next;
      bus.req_read   <= (state == IDLE) && !bus.req_empty;
      bus.resp_write <= push;
      if ((state == IDLE) && !bus.req_empty) req_q <= bus.req_data;
      if (push) begin
        bus.resp_data <= {op, addr, resp_payload};
        txn_count     <= txn_count + 16'd1;
      end
    end
  end

`ifdef ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (push && !addr_ok && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`else
  assign err_count = '0;
`endif

  // Not reset: RAM survives rst, but a request caught by rst in EXEC must not commit.
  always_ff @(posedge clk) begin
    if (!rst && (state == EXEC)) begin
      if (op && addr_ok) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end
endmodule

// File: tb/tb_bram_request_responder.sv
// tb/tb_bram_request_responder.sv - scoreboard bench for bram_request_responder (ADDR_BITS=10)
module tb_bram_request_responder;
  localparam int AB = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state_out;
  logic [15:0] txn_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  bram_request_responder_if bus();

  bram_request_responder #(.ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_out (state_out),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  logic [40:0] req_fifo [$];
  logic [40:0] exp_q [$];
  logic [15:0] model_mem [int];
  int n_assert = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_resp   = 0;
  int cyc      = 0;
  int last_pop = -100;
  int last_resp = -100;
  int min_gap  = 1000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_req(input logic op, input logic [23:0] a, input logic [15:0] d);
    logic [40:0] e;
    logic [15:0] rd;
    int idx;
    idx = int'(a[AB-1:0]);
    rd  = model_mem.exists(idx) ? model_mem[idx] : 16'h0000;
    e   = op ? {op, a, d} : {op, a, rd};
`ifdef ADDR_CHECK_EN
    if (a[23:AB] != '0) begin
      e = {op, a, 16'hDEAD};
    end else if (op) begin
      model_mem[idx] = d;
    end
`else
    if (op) model_mem[idx] = d;
`endif
    req_fifo.push_back({op, a, d});
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget && (exp_q.size() != 0 || req_fifo.size() != 0 || state_out != 4'd0); i++)
      step(1);
    check("drain_timeout", 64'(i < budget), 64'd1);
  endtask

  // FWFT request FIFO model plus response scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.req_read === 1'b1) begin
      if (req_fifo.size() > 0) void'(req_fifo.pop_front());
      if (cyc - last_pop < min_gap) min_gap = cyc - last_pop;
      last_pop = cyc;
      n_pop++;
    end
    bus.req_empty = (req_fifo.size() == 0);
    bus.req_data  = (req_fifo.size() == 0) ? 41'h0 : req_fifo[0];
    if (bus.resp_write === 1'b1) begin
      n_resp++;
      last_resp = cyc;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL resp_unexpected observed=%0h expected=none", bus.resp_data);
      end else begin
        check("resp_data", 64'(bus.resp_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int p0;
    int r0;
    int i;
    rst = 1'b1;
    bus.resp_full = 1'b0;
    step(3);
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_req_read", 64'(bus.req_read), 64'd0);
    check("rst_resp_write", 64'(bus.resp_write), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    rst = 1'b0;
    step(2);

    // 1: write then read back
    push_req(1'b1, 24'h000005, 16'h1234);
    push_req(1'b0, 24'h000005, 16'h0000);
    check("t1_exp_wr", 64'(exp_q[0]), 64'({1'b1, 24'h000005, 16'h1234}));
    check("t1_exp_rd", 64'(exp_q[1]), 64'({1'b0, 24'h000005, 16'h1234}));
    drain(60);
    check("t1_txn", 64'(txn_count), 64'd2);
    check("t1_latency", 64'(last_resp - last_pop), 64'd2);

    // 2: response FIFO full stalls in RESP
    p0 = n_pop;
    r0 = n_resp;
    bus.resp_full = 1'b1;
    push_req(1'b0, 24'h000005, 16'h0000);
    step(4);
    for (i = 0; i < 10; i++) begin
      check("t2_stall", 64'({state_out, bus.resp_write}), 64'({4'd2, 1'b0}));
      step(1);
    end
    bus.resp_full = 1'b0;
    drain(60);
    check("t2_one_resp", 64'(n_resp - r0), 64'd1);
    check("t2_one_pop", 64'(n_pop - p0), 64'd1);

    // 3: eight back-to-back requests
    r0 = n_resp;
    min_gap = 1000;
    for (i = 0; i < 4; i++) begin
      push_req(1'b1, 24'(i), 16'hA000 + 16'(i * 16'h0111));
      push_req(1'b0, 24'(i), 16'h0000);
    end
    drain(200);
    check("t3_resp_count", 64'(n_resp - r0), 64'd8);
    check("t3_pop_gap_ge4", 64'(min_gap >= 4), 64'd1);
    check("t3_txn", 64'(txn_count), 64'd11);

    // 4/5: aliased or rejected upper address
    push_req(1'b1, 24'h000405, 16'hBEEF);
    push_req(1'b0, 24'h000005, 16'h0000);
`ifdef ADDR_CHECK_EN
    check("t5_exp_wr", 64'(exp_q[0]), 64'({1'b1, 24'h000405, 16'hDEAD}));
    check("t5_exp_rd", 64'(exp_q[1]), 64'({1'b0, 24'h000005, 16'h1234}));
`else
    check("t4_exp_rd", 64'(exp_q[1]), 64'({1'b0, 24'h000005, 16'hBEEF}));
`endif
    drain(60);
`ifdef ADDR_CHECK_EN
    check("t5_err", 64'(err_count), 64'd1);
`else
    check("t4_err", 64'(err_count), 64'd0);
`endif

    // 6: reset while waiting in RESP drops the popped request
    bus.resp_full = 1'b1;
    push_req(1'b0, 24'h000005, 16'h0000);
    for (i = 0; i < 20 && state_out != 4'd2; i++) step(1);
    check("t6_reach_resp", 64'(state_out), 64'd2);
    r0 = n_resp;
    rst = 1'b1;
    step(1);
    check("t6_rst_state", 64'(state_out), 64'd0);
    check("t6_rst_resp_write", 64'(bus.resp_write), 64'd0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    bus.resp_full = 1'b0;
    step(6);
    check("t6_no_resp", 64'(n_resp - r0), 64'd0);
    check("t6_txn_cleared", 64'(txn_count), 64'd0);
    push_req(1'b0, 24'h000005, 16'h0000);
`ifdef ADDR_CHECK_EN
    check("t6_exp_rd", 64'(exp_q[0]), 64'({1'b0, 24'h000005, 16'h1234}));
`else
    check("t6_exp_rd", 64'(exp_q[0]), 64'({1'b0, 24'h000005, 16'hBEEF}));
`endif
    drain(60);
    check("t6_txn", 64'(txn_count), 64'd1);
    check("t6_resp_count", 64'(n_resp - r0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
